peridot_board_i2c_avm: RTL and testbench
========================================

# peridot_board_i2c_avm

I2C slave transaction layer sitting directly above the PERIDOT byte-level I2C serial interface, consuming its start/stop/byte/ack event pulses and driving its ack, clock-stretch and transmit-data inputs. It decodes the device-address byte, keeps an 8-bit register pointer, and converts I2C write and read bursts into single-byte Avalon-MM master transfers with pointer auto-increment. The SCL low phase is stretched through `ackwaitrequest` while each Avalon transfer is outstanding.

## Interface
- `DEVICE_ADDR`, 7'h50, 7-bit I2C slave address this block acknowledges.
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `condi_start`  in  1  pulse: START or repeated START detected.
- `condi_stop`  in  1  pulse: STOP detected.
- `done_byte`  in  1  pulse: 8 bits received; `recieve_bytedata` valid this cycle.
- `done_ack`  in  1  pulse: 9th SCL fall; `recieve_ackdata` valid this cycle.
- `recieve_bytedata`  in  8  received byte, MSB first.
- `recieve_ackdata`  in  1  master ACK on a read byte (1 = ACK, 0 = NACK).
- `ackwaitrequest`  out  1  1 = hold SCL low in the ack phase.
- `send_ackdata`  out  1  1 = drive ACK (SDA low) in the ack phase; 0 = release SDA.
- `send_bytedata`  out  8  next byte to transmit; loaded by the byte core at `done_ack`.
- `send_bytedatavalid`  out  1  1 = `send_bytedata` valid; 0 = byte core transmits 8'hFF.
- `avm_address`  out  8  Avalon-MM address, equal to the register pointer.
- `avm_write`  out  1  write request.
- `avm_writedata`  out  8  write data.
- `avm_read`  out  1  read request.
- `avm_waitrequest`  in  1  slave stall.
- `avm_readdata`  in  8  read data.
- `avm_readdatavalid`  in  1  read data strobe.
- `busy`  out  1  1 while the state is not IDLE or an Avalon transfer is outstanding.

## Operation
- States: IDLE, DEV, REG, WR, RD, IGN. Register pointer `ptr[7:0]`.
- `condi_start` in any state: go to DEV. `ptr` is kept, so a repeated START supports write-pointer-then-read.
- `condi_stop` in any state: go to IDLE. If both pulse in the same cycle, `condi_start` wins.
- At `done_byte` in DEV, compare `recieve_bytedata[7:1]` with `DEVICE_ADDR`.
  - Mismatch: `send_ackdata`=0, go to IGN.
  - Match with bit 0 = 0: `send_ackdata`=1, go to REG.
  - Match with bit 0 = 1: `send_ackdata`=1, issue an Avalon read at `ptr`, go to RD.
- At `done_byte` in REG: `ptr`←byte, `send_ackdata`=1, go to WR.
- At `done_byte` in WR: issue an Avalon write of the byte at `ptr`, `send_ackdata`=1. On completion, `ptr`←`ptr`+1.
- RD state:
  - Avalon read completion latches `send_bytedata`, sets `send_bytedatavalid`=1, and does `ptr`←`ptr`+1.
  - At `done_byte` in RD: `send_ackdata`=0 (master owns the ack bit). Prefetch the next read at `ptr`.
  - At `done_ack` with `recieve_ackdata`=0: clear `send_bytedatavalid`, go to IGN. The one prefetched read is discarded, which is an accepted side effect.
- IGN: `send_ackdata`=0, `send_bytedatavalid`=0, no Avalon traffic.
- `ptr` wraps 8'hFF→8'h00.
- Avalon write completes on the first cycle with `avm_write`=1 and `avm_waitrequest`=0. Read command completes likewise; data completes on `avm_readdatavalid`.
- Only one transfer is outstanding at a time. A START or STOP mid-transfer does not abort it: the transfer finishes, read data is dropped if the state is no longer RD, and `ptr` still increments.

## Timing
- Reset values: `ackwaitrequest`=0, `send_ackdata`=0, `send_bytedata`=8'hFF, `send_bytedatavalid`=0, `avm_write`=0, `avm_read`=0, `avm_address`=0, `avm_writedata`=0, `busy`=0, `ptr`=0, state IDLE.
- `ackwaitrequest`:
  - Registered; rises the cycle after every `done_byte` in DEV, REG, WR and RD.
  - With no Avalon transfer it stays high exactly 1 cycle.
  - With a transfer it stays high until the cycle after the write accept or the `avm_readdatavalid` cycle.
- `send_ackdata` is valid no later than the first cycle of `ackwaitrequest`=1 and is held until the next `done_byte`.
- `avm_read` and `avm_write` assert the cycle after `done_byte`, held until `avm_waitrequest`=0.
- `send_bytedata` and `send_bytedatavalid` are stable at least 1 cycle before `ackwaitrequest` falls. The byte core loads them at `done_ack`.
- The initial DEV-read must also complete before `ackwaitrequest` falls.

## Test plan
- Write burst: START, 0xA0, 0x10, 0x11, 0x22, STOP → ACK on all 4 bytes; Avalon writes 0x11@0x10 and 0x22@0x11; `ptr`=0x12; `busy`=0 after STOP.
- Write-then-read: START, 0xA0, 0x40, repeated START, 0xA1; slave returns 0x5A@0x40 and 0x6B@0x41; master ACK then NACK → bytes 0x5A, 0x6B sent; NACK → IGN; 3 Avalon reads (0x40, 0x41, 0x42 prefetch).
- Address mismatch: START, 0xB0, 0x00, STOP → `send_ackdata`=0 throughout; no Avalon strobes; `ackwaitrequest` high 1 cycle after the address byte only.
- Clock stretch: `avm_waitrequest` held 20 cycles on a write → `ackwaitrequest` high 21 cycles; ACK released afterward; write accepted once.
- Wrap: pointer 0xFF, write 2 bytes → Avalon addresses 0xFF then 0x00.
- Reset during a stretched read → all outputs return to reset values asynchronously; next START/0xA1 reads from `ptr`=0x00.

Source files
------------

// File: rtl/peridot_board_i2c_avm.sv
// I2C slave transaction layer: decodes device address and register pointer, and turns
// I2C write/read bursts into single-byte Avalon-MM transfers while stretching SCL.
`timescale 1ns/1ps
module peridot_board_i2c_avm #(
    parameter logic [6:0] DEVICE_ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       condi_start,
    input  logic       condi_stop,
    input  logic       done_byte,
    input  logic       done_ack,
    input  logic [7:0] recieve_bytedata,
    input  logic       recieve_ackdata,
    output logic       ackwaitrequest,
    output logic       send_ackdata,
    output logic [7:0] send_bytedata,
    output logic       send_bytedatavalid,
    output logic [7:0] avm_address,
    output logic       avm_write,
    output logic [7:0] avm_writedata,
    output logic       avm_read,
    input  logic       avm_waitrequest,
    input  logic [7:0] avm_readdata,
    input  logic       avm_readdatavalid,
    output logic       busy
);

    typedef enum logic [2:0] {StIdle, StDev, StReg, StWr, StRd, StIgn} state_t;

    state_t     r_state, w_state_next;
    logic [7:0] r_ptr, r_txdata, r_wdata;
    logic       r_ackwait, r_ackdata, r_txvalid, r_wr, r_rd, r_rd_pend;
    logic       w_xfer, w_hold, w_hit, w_wr_done, w_rd_cmd_done, w_rd_data;
    logic       w_trig, w_ack_upd, w_ack_val, w_issue_wr, w_issue_rd, w_ptr_load;

    assign w_xfer        = r_wr | r_rd | r_rd_pend;
    assign w_wr_done     = r_wr & ~avm_waitrequest;
    assign w_rd_cmd_done = r_rd & ~avm_waitrequest;
    assign w_rd_data     = r_rd_pend & avm_readdatavalid;
    assign w_hit         = (recieve_bytedata[7:1] == DEVICE_ADDR);
    // Reads hold the stretch one cycle past readdatavalid so the new tx byte settles first.
    assign w_hold        = (r_wr & avm_waitrequest) | r_rd | r_rd_pend;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_trig       = 1'b0;
        w_ack_upd    = 1'b0;
        w_ack_val    = 1'b0;
        w_issue_wr   = 1'b0;
        w_issue_rd   = 1'b0;
        w_ptr_load   = 1'b0;
        if (condi_start) begin
            w_state_next = StDev;
        end else if (condi_stop) begin
            w_state_next = StIdle;
        end else if (done_byte) begin
            w_ack_upd = 1'b1;
            case (r_state)
                StDev: begin
                    w_trig = 1'b1;
                    if (!w_hit) begin
                        w_state_next = StIgn;
                    end else begin
                        w_ack_val = 1'b1;
                        if (recieve_bytedata[0]) begin
                            w_issue_rd   = 1'b1;
                            w_state_next = StRd;
                        end else begin
                            w_state_next = StReg;
                        end
                    end
                end
                StReg: begin
                    w_trig       = 1'b1;
                    w_ack_val    = 1'b1;
                    w_ptr_load   = 1'b1;
                    w_state_next = StWr;
                end
                StWr: begin
                    w_trig     = 1'b1;
                    w_ack_val  = 1'b1;
                    w_issue_wr = 1'b1;
                end
                StRd: begin
                    w_trig     = 1'b1;
                    w_issue_rd = 1'b1;
                end
                default: ;
            endcase
        end else if (done_ack && r_state == StRd && !recieve_ackdata) begin
            w_state_next = StIgn;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ackwait <= 1'b0;
            r_ackdata <= 1'b0;
            r_txdata  <= 8'hFF;
            r_txvalid <= 1'b0;
            r_wr      <= 1'b0;
            r_rd      <= 1'b0;
            r_rd_pend <= 1'b0;
            r_wdata   <= 8'h00;
            r_ptr     <= 8'h00;
        end else begin
            r_ackwait <= w_trig | (r_ackwait & w_hold);
            if (w_ack_upd) begin
                r_ackdata <= w_ack_val;
            end
            if (w_ptr_load) begin
                r_ptr <= recieve_bytedata;
            end else if (w_wr_done || w_rd_data) begin
                r_ptr <= r_ptr + 8'd1;
            end
            if (w_wr_done) begin
                r_wr <= 1'b0;
            end
            if (w_rd_cmd_done) begin
                r_rd      <= 1'b0;
                r_rd_pend <= 1'b1;
            end
            if (w_rd_data) begin
                r_rd_pend <= 1'b0;
            end
            if (!w_xfer) begin
                if (w_issue_wr) begin
                    r_wr    <= 1'b1;
                    r_wdata <= recieve_bytedata;
                end
                if (w_issue_rd) begin
                    r_rd <= 1'b1;
                end
            end
            // Read data arriving after the burst has left RD is dropped.
            if (w_rd_data && w_state_next == StRd) begin
                r_txdata  <= avm_readdata;
                r_txvalid <= 1'b1;
            end else if (w_state_next inside {StIdle, StDev, StIgn}) begin
                r_txvalid <= 1'b0;
            end
        end
    end

    assign ackwaitrequest     = r_ackwait;
    assign send_ackdata       = r_ackdata;
    assign send_bytedata      = r_txdata;
    assign send_bytedatavalid = r_txvalid;
    assign avm_address        = r_ptr;
    assign avm_write          = r_wr;
    assign avm_writedata      = r_wdata;
    assign avm_read           = r_rd;
    assign busy               = (r_state != StIdle) | w_xfer;

endmodule

// File: tb/tb_peridot_board_i2c_avm.sv
// Scoreboard bench: stimulus acts as byte core and I2C master, a slave model answers Avalon,
// monitors pop expected Avalon transfers, ACK values and transmitted bytes.
`timescale 1ns/1ps
module tb_peridot_board_i2c_avm;

    logic       clk = 1'b0;
    logic       reset, condi_start, condi_stop, done_byte, done_ack;
    logic [7:0] recieve_bytedata;
    logic       recieve_ackdata;
    logic       ackwaitrequest, send_ackdata, send_bytedatavalid;
    logic [7:0] send_bytedata, avm_address, avm_writedata, avm_readdata;
    logic       avm_write, avm_read, avm_waitrequest, avm_readdatavalid, busy;

    always #5 clk = ~clk;

    peridot_board_i2c_avm #(.DEVICE_ADDR(7'h50)) dut (
        .clk(clk), .reset(reset), .condi_start(condi_start), .condi_stop(condi_stop),
        .done_byte(done_byte), .done_ack(done_ack), .recieve_bytedata(recieve_bytedata),
        .recieve_ackdata(recieve_ackdata), .ackwaitrequest(ackwaitrequest),
        .send_ackdata(send_ackdata), .send_bytedata(send_bytedata),
        .send_bytedatavalid(send_bytedatavalid), .avm_address(avm_address),
        .avm_write(avm_write), .avm_writedata(avm_writedata), .avm_read(avm_read),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid), .busy(busy)
    );

    typedef struct packed {
        logic       is_wr;
        logic [7:0] addr;
        logic [7:0] data;
    } av_t;

    av_t        exp_av[$];
    logic       exp_ack[$];
    logic [7:0] exp_tx[$];
    logic [7:0] wq[$];
    logic [7:0] slave_mem[256];
    logic [7:0] ref_mem[256];
    logic [7:0] ref_ptr;
    int         errors = 0;
    int         checks = 0;
    int         force_stall = -1;
    int         last_len = 0;
    int         aw_len = 0;
    int         aw_rises = 0;
    logic       aw_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic av_t mk_av(input logic w, input logic [7:0] a, input logic [7:0] d);
        av_t e;
        e.is_wr = w;
        e.addr  = a;
        e.data  = d;
        return e;
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Avalon slave model with optional forced stall length.
    initial begin
        int   stall;
        int   rd_lat;
        logic cmd_active;
        logic [7:0] rd_data;
        stall = 0; rd_lat = 0; cmd_active = 1'b0; rd_data = 8'h00;
        avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            avm_readdatavalid = 1'b0;
            if (reset) begin
                cmd_active = 1'b0; rd_lat = 0; avm_waitrequest = 1'b0;
            end else begin
                if (rd_lat > 0) begin
                    rd_lat--;
                    if (rd_lat == 0) begin
                        avm_readdatavalid = 1'b1;
                        avm_readdata = rd_data;
                    end
                end
                if ((avm_write || avm_read) && !cmd_active) begin
                    cmd_active = 1'b1;
                    stall = (force_stall >= 0) ? force_stall : $urandom_range(0, 2);
                end
                if (cmd_active) begin
                    if (stall > 0) begin
                        avm_waitrequest = 1'b1;
                        stall--;
                    end else begin
                        avm_waitrequest = 1'b0;
                        cmd_active = 1'b0;
                        if (avm_read) begin
                            rd_lat  = $urandom_range(1, 3);
                            rd_data = slave_mem[avm_address];
                        end
                        if (avm_write) slave_mem[avm_address] = avm_writedata;
                    end
                end else begin
                    avm_waitrequest = 1'b0;
                end
            end
        end
    end

    // Monitor: Avalon accepts, ACK at stretch start, tx byte at done_ack.
    initial begin
        av_t        e;
        logic [7:0] t;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if ((avm_write || avm_read) && !avm_waitrequest) begin
                    if (exp_av.size() == 0) begin
                        chk("av_unexpected", {avm_write, avm_read, avm_address}, 0);
                    end else begin
                        e = exp_av.pop_front();
                        if (e.is_wr)
                            chk("av_write", {avm_write, avm_read, avm_address, avm_writedata},
                                {1'b1, 1'b0, e.addr, e.data});
                        else
                            chk("av_read", {avm_write, avm_read, avm_address},
                                {1'b0, 1'b1, e.addr});
                    end
                end
                if (ackwaitrequest && !aw_prev) begin
                    aw_rises++;
                    if (exp_ack.size() == 0) chk("ack_unexpected_stretch", 1, 0);
                    else chk("ack_value", send_ackdata, exp_ack.pop_front());
                end
                if (ackwaitrequest) begin
                    aw_len++;
                end else if (aw_prev) begin
                    last_len = aw_len;
                    aw_len = 0;
                end
                if (done_ack && exp_tx.size() > 0) begin
                    t = exp_tx.pop_front();
                    chk("tx_byte", {send_bytedatavalid, send_bytedata}, {1'b1, t});
                end
            end else begin
                aw_len = 0;
            end
            aw_prev = ackwaitrequest;
        end
    end

    task automatic pulse_start();
        condi_start = 1'b1; step(1); condi_start = 1'b0; step(2);
    endtask

    task automatic pulse_stop();
        condi_stop = 1'b1; step(1); condi_stop = 1'b0; step(2);
    endtask

    task automatic i2c_byte(input logic [7:0] b, input bit stretch, input logic ack_exp,
                            input logic mack, input bit tx_chk, input logic [7:0] tx_exp);
        int n;
        if (stretch) exp_ack.push_back(ack_exp);
        recieve_bytedata = b; done_byte = 1'b1; step(1); done_byte = 1'b0;
        n = 0;
        while (ackwaitrequest && n < 300) begin
            step(1);
            n++;
        end
        if (n >= 300) chk("stretch_timeout", n, 0);
        step(2);
        if (tx_chk) exp_tx.push_back(tx_exp);
        recieve_ackdata = mack; done_ack = 1'b1; step(1); done_ack = 1'b0; step(2);
    endtask

    task automatic set_ptr(input logic [7:0] p);
        pulse_start();
        i2c_byte(8'hA0, 1, 1'b1, 1'b1, 0, 8'h00);
        i2c_byte(p, 1, 1'b1, 1'b1, 0, 8'h00);
        ref_ptr = p;
    endtask

    task automatic do_write(input logic [7:0] p);
        set_ptr(p);
        foreach (wq[i]) begin
            exp_av.push_back(mk_av(1'b1, ref_ptr, wq[i]));
            ref_mem[ref_ptr] = wq[i];
            ref_ptr = ref_ptr + 8'd1;
            i2c_byte(wq[i], 1, 1'b1, 1'b1, 0, 8'h00);
        end
        pulse_stop(); step(2);
        chk("busy_after_write", busy, 0);
    endtask

    // Address read plus n data bytes; the last one is NACKed.
    task automatic do_read(input int n);
        logic [7:0] a;
        pulse_start();
        a = ref_ptr;
        exp_av.push_back(mk_av(1'b0, a, 8'h00));
        ref_ptr = ref_ptr + 8'd1;
        i2c_byte(8'hA1, 1, 1'b1, 1'b1, 1, ref_mem[a]);
        for (int i = 0; i < n; i++) begin
            a = ref_ptr;
            exp_av.push_back(mk_av(1'b0, a, 8'h00));
            ref_ptr = ref_ptr + 8'd1;
            i2c_byte(8'hFF, 1, 1'b0, (i < n - 1), (i < n - 1), ref_mem[a]);
        end
        chk("txvalid_after_nack", send_bytedatavalid, 0);
        pulse_stop(); step(2);
        chk("busy_after_read", busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [6:0] bad;
        int         r0;
        reset = 1'b1; condi_start = 1'b0; condi_stop = 1'b0; done_byte = 1'b0;
        done_ack = 1'b0; recieve_bytedata = 8'h00; recieve_ackdata = 1'b0;
        ref_ptr = 8'h00;
        for (int i = 0; i < 256; i++) begin
            slave_mem[i] = 8'($urandom);
            ref_mem[i] = slave_mem[i];
        end
        step(3);
        chk("reset_outputs", {ackwaitrequest, send_ackdata, send_bytedata, send_bytedatavalid,
                              avm_write, avm_read, avm_address, avm_writedata, busy},
            {1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0});
        reset = 1'b0;
        step(2);

        // Write burst, then read back from the advanced pointer.
        wq.delete(); wq.push_back(8'h11); wq.push_back(8'h22);
        do_write(8'h10);
        chk("ptr_after_burst", ref_ptr, 8'h12);
        do_read(1);

        // Write pointer, repeated START, read two bytes.
        slave_mem[8'h40] = 8'h5A; ref_mem[8'h40] = 8'h5A;
        slave_mem[8'h41] = 8'h6B; ref_mem[8'h41] = 8'h6B;
        set_ptr(8'h40);
        do_read(2);

        // Address mismatch: one stretch with NACK, no Avalon strobes.
        bad = 7'($urandom_range(0, 127));
        if (bad == 7'h50) bad = 7'h51;
        r0 = aw_rises;
        pulse_start();
        i2c_byte({bad, 1'($urandom_range(0, 1))}, 1, 1'b0, 1'b1, 0, 8'h00);
        i2c_byte(8'h00, 0, 1'b0, 1'b1, 0, 8'h00);
        pulse_stop();
        chk("mismatch_stretch_count", aw_rises - r0, 1);

        // Long stall on a write.
        force_stall = 20;
        wq.delete(); wq.push_back(8'($urandom));
        do_write(8'($urandom));
        chk("stretch_len_20_stall", last_len, 21);
        force_stall = -1;

        // Pointer wrap.
        wq.delete(); wq.push_back(8'($urandom)); wq.push_back(8'($urandom));
        do_write(8'hFF);
        chk("ptr_wrapped", ref_ptr, 8'h01);

        // Reset in the middle of a stretched read.
        pulse_start();
        force_stall = 30;
        exp_ack.push_back(1'b1);
        recieve_bytedata = 8'hA1; done_byte = 1'b1; step(1); done_byte = 1'b0;
        step(5);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_outputs", {ackwaitrequest, send_ackdata, send_bytedata,
                                    send_bytedatavalid, avm_write, avm_read, avm_address,
                                    avm_writedata, busy},
            {1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0});
        exp_av.delete(); exp_tx.delete(); exp_ack.delete();
        force_stall = -1;
        step(2);
        reset = 1'b0;
        ref_ptr = 8'h00;
        step(2);
        do_read(2);

        // Randomized transactions.
        for (int it = 0; it < 8; it++) begin
            case ($urandom_range(0, 2))
                0: begin
                    wq.delete();
                    for (int k = 0; k < int'($urandom_range(1, 4)); k++) wq.push_back(8'($urandom));
                    do_write(8'($urandom));
                end
                1: do_read(int'($urandom_range(1, 3)));
                default: begin
                    set_ptr(8'($urandom));
                    do_read(int'($urandom_range(1, 3)));
                end
            endcase
        end

        step(10);
        chk("av_queue_drained", exp_av.size(), 0);
        chk("ack_queue_drained", exp_ack.size(), 0);
        chk("tx_queue_drained", exp_tx.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
